// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller.
//  - forward-select encodings used by the E-stage operand muxes
//  - syscall drain FSM states
//  - REG_ZERO: the hardwired-zero register, which never takes part in a hazard
package hazard_ctrl_pkg;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwdSel_e;

  typedef enum logic [1:0] {IDLE, DRAIN, ISSUE} sysState_e;

  // A write to reg 0 is discarded, so a compare against it must never match.
  function automatic logic regHit(input logic [4:0] src, input logic [4:0] dst);
    return (src != REG_ZERO) && (src == dst);
  endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-unit bundle between the 5-stage datapath and hazard_ctrl.
//  master: datapath side (drives register ids/controls, receives stalls/selects)
//  slave : hazard_ctrl side
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0]       RsD, RtD, RsE, RtE;
  logic [4:0]       WriteRegE, WriteRegM, WriteRegW;
  logic             RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW;
  logic             BranchD, sysD;
  logic             StallF, StallD, FlushE;
  logic             ForwardAD, ForwardBD;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             sysGoD;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW, BranchD, sysD,
    input  StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
           sysGoD, stall_cnt
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW, BranchD, sysD,
    output StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
           sysGoD, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// fwd_sel: compares one source register against the M and W destinations.
//  src                   : source register being read
//  writeRegM/regWriteM   : M-stage destination and write enable
//  writeRegW/regWriteW   : W-stage destination and write enable
//  sel                   : FWD_M (newest value wins), else FWD_W, else FWD_RF
module fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] writeRegM,
  input  logic       regWriteM,
  input  logic [4:0] writeRegW,
  input  logic       regWriteW,
  output fwdSel_e    sel
);
  always_comb begin
    sel = FWD_RF;
    if (regWriteM && regHit(src, writeRegM))      sel = FWD_M;
    else if (regWriteW && regHit(src, writeRegW)) sel = FWD_W;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control for the 5-stage core, plus a
// syscall drain FSM and a saturating stall-cycle counter.
//  clk, reset : core clock, synchronous active-high reset
//  hz         : hazard bundle (slave side) -- register ids and controls in,
//               StallF/StallD/FlushE, Forward{A,B}{D,E}, sysGoD, stall_cnt out
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input logic     clk,
  input logic     reset,
  hazard_ctrl_if.slave hz
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  fwdSel_e aeSel, beSel, adSel, bdSel;

  fwd_sel uFwdAE (.src(hz.RsE), .writeRegM(hz.WriteRegM), .regWriteM(hz.RegWriteM),
                  .writeRegW(hz.WriteRegW), .regWriteW(hz.RegWriteW), .sel(aeSel));
  fwd_sel uFwdBE (.src(hz.RtE), .writeRegM(hz.WriteRegM), .regWriteM(hz.RegWriteM),
                  .writeRegW(hz.WriteRegW), .regWriteW(hz.RegWriteW), .sel(beSel));
  // D-stage forwarding only has an ALUOutM path; W is written before D reads
  // the register file, so only the M match is used from these two.
  fwd_sel uFwdAD (.src(hz.RsD), .writeRegM(hz.WriteRegM), .regWriteM(hz.RegWriteM),
                  .writeRegW(hz.WriteRegW), .regWriteW(hz.RegWriteW), .sel(adSel));
  fwd_sel uFwdBD (.src(hz.RtD), .writeRegM(hz.WriteRegM), .regWriteM(hz.RegWriteM),
                  .writeRegW(hz.WriteRegW), .regWriteW(hz.RegWriteW), .sel(bdSel));

  logic lwStall, brStall, hazStall;

  assign lwStall = hz.MemtoRegE && (regHit(hz.RtE, hz.RsD) || regHit(hz.RtE, hz.RtD));
  assign brStall = hz.BranchD &&
                   ((hz.RegWriteE && (regHit(hz.WriteRegE, hz.RsD) || regHit(hz.WriteRegE, hz.RtD))) ||
                    (hz.MemtoRegM && (regHit(hz.WriteRegM, hz.RsD) || regHit(hz.WriteRegM, hz.RtD))));
  assign hazStall = lwStall || brStall;

  sysState_e       state, stateNx;
  logic [DW-1:0]   dCnt, dCntNx;
  logic            stall, sysGo;
  logic [CNT_W-1:0] stallCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      dCnt  <= '0;
    end else begin
      state <= stateNx;
      dCnt  <= dCntNx;
    end
  end

  always_comb begin
    stateNx = state;
    dCntNx  = dCnt;
    stall   = hazStall;
    sysGo   = 1'b0;
    case (state)
      IDLE: begin
        // A pending load-use/branch stall is resolved before the drain starts.
        if (hz.sysD && !hazStall) begin
          stateNx = DRAIN;
          dCntNx  = DW'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        // sysD is not re-checked here: once draining, the syscall always issues.
        stall  = 1'b1;
        dCntNx = dCnt - 1'b1;
        if (dCnt <= DW'(1)) stateNx = ISSUE;
      end
      ISSUE: begin
        stall   = 1'b0;
        sysGo   = 1'b1;
        stateNx = IDLE;
      end
      default: stateNx = IDLE;
    endcase
  end

  // Reset holds E flushed and disables every stall/forward immediately.
  assign hz.StallF    = !reset && stall;
  assign hz.StallD    = !reset && stall;
  assign hz.FlushE    = reset || stall;
  assign hz.sysGoD    = !reset && sysGo;
  assign hz.ForwardAE = reset ? FWD_RF : aeSel;
  assign hz.ForwardBE = reset ? FWD_RF : beSel;
  assign hz.ForwardAD = !reset && (adSel == FWD_M);
  assign hz.ForwardBD = !reset && (bdSel == FWD_M);

  always_ff @(posedge clk) begin
    if (reset)                              stallCnt <= '0;
    else if (hz.StallD && stallCnt != '1)   stallCnt <= stallCnt + 1'b1;
  end

  assign hz.stall_cnt = stallCnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset, reset2;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(16)) hz ();
  hazard_ctrl_if #(.CNT_W(4))  hz2 ();

  hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut  (.clk(clk), .reset(reset),  .hz(hz));
  hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4))  dut2 (.clk(clk), .reset(reset2), .hz(hz2));

  typedef struct {
    logic [4:0] RsD, RtD, RsE, RtE, WrE;
    logic       RwE, MtrE;
    logic [4:0] WrM;
    logic       RwM, MtrM;
    logic [4:0] WrW;
    logic       RwW, Br;
    logic [1:0] eAE, eBE;
    logic       eAD, eBD, eStall;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    hz.RsD = 0; hz.RtD = 0; hz.RsE = 0; hz.RtE = 0;
    hz.WriteRegE = 0; hz.WriteRegM = 0; hz.WriteRegW = 0;
    hz.RegWriteE = 0; hz.MemtoRegE = 0; hz.RegWriteM = 0; hz.MemtoRegM = 0;
    hz.RegWriteW = 0; hz.BranchD = 0; hz.sysD = 0;
  endtask

  task automatic chkCtl(input string nm, input logic st, input logic fl, input logic go);
    #1;
    chk({nm, ".StallF"}, 32'(hz.StallF), 32'(st));
    chk({nm, ".StallD"}, 32'(hz.StallD), 32'(st));
    chk({nm, ".FlushE"}, 32'(hz.FlushE), 32'(fl));
    chk({nm, ".sysGoD"}, 32'(hz.sysGoD), 32'(go));
  endtask

  initial begin
    //        RsD   RtD   RsE   RtE   WrE  RwE MtrE WrM  RwM MtrM WrW  RwW Br   AE     BE    AD BD St
    vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 0, 0, 5'd5, 1, 0, 5'd5, 1, 0, 2'b10, 2'b00, 0, 0, 0};
    vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 0, 0, 5'd5, 0, 0, 5'd5, 1, 0, 2'b01, 2'b00, 0, 0, 0};
    vecs[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 5'd0, 1, 0, 2'b00, 2'b00, 0, 0, 0};
    vecs[3]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 1, 5'd0, 0, 0, 5'd0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
    vecs[4]  = '{5'd0, 5'd8, 5'd0, 5'd8, 5'd0, 0, 1, 5'd0, 0, 0, 5'd0, 0, 0, 2'b00, 2'b00, 0, 0, 1};
    vecs[5]  = '{5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 0, 0, 5'd7, 0, 0, 5'd7, 1, 0, 2'b00, 2'b01, 0, 0, 0};
    vecs[6]  = '{5'd3, 5'd4, 5'd0, 5'd0, 5'd0, 0, 0, 5'd4, 1, 0, 5'd0, 0, 0, 2'b00, 2'b00, 0, 1, 0};
    vecs[7]  = '{5'd9, 5'd0, 5'd0, 5'd0, 5'd9, 1, 0, 5'd0, 0, 0, 5'd0, 0, 1, 2'b00, 2'b00, 0, 0, 1};
    vecs[8]  = '{5'd0, 5'd10,5'd0, 5'd0, 5'd0, 0, 0, 5'd10,1, 1, 5'd0, 0, 1, 2'b00, 2'b00, 0, 1, 1};
    vecs[9]  = '{5'd9, 5'd0, 5'd0, 5'd0, 5'd9, 0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 2'b00, 2'b00, 0, 0, 0};
    vecs[10] = '{5'd9, 5'd0, 5'd0, 5'd0, 5'd9, 1, 0, 5'd0, 0, 0, 5'd0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
    vecs[11] = '{5'd12,5'd0, 5'd0, 5'd12,5'd0, 0, 1, 5'd0, 0, 0, 5'd0, 0, 0, 2'b00, 2'b00, 0, 0, 1};
    vecs[12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1, 0, 5'd0, 0, 0, 5'd0, 0, 1, 2'b00, 2'b00, 0, 0, 0};

    // Second instance: permanent load-use stall, held in reset first.
    hz2.RsD = 0; hz2.RtD = 5'd8; hz2.RsE = 0; hz2.RtE = 5'd8;
    hz2.WriteRegE = 0; hz2.WriteRegM = 0; hz2.WriteRegW = 0;
    hz2.RegWriteE = 0; hz2.MemtoRegE = 1; hz2.RegWriteM = 0; hz2.MemtoRegM = 0;
    hz2.RegWriteW = 0; hz2.BranchD = 0; hz2.sysD = 0;
    reset2 = 1'b1;

    // Reset with active forwarding/hazard inputs: outputs forced quiet, E flushed.
    clearIn();
    reset = 1'b1;
    hz.RsE = 5'd5; hz.WriteRegM = 5'd5; hz.RegWriteM = 1;
    hz.RsD = 5'd5; hz.MemtoRegE = 1; hz.RtE = 5'd5;
    step(); step();
    chkCtl("rst", 1'b0, 1'b1, 1'b0);
    chk("rst.ForwardAE", 32'(hz.ForwardAE), 32'd0);
    chk("rst.ForwardAD", 32'(hz.ForwardAD), 32'd0);
    chk("rst.stall_cnt", 32'(hz.stall_cnt), 32'd0);
    chk("rst2.stall_cnt", 32'(hz2.stall_cnt), 32'd0);
    reset2 = 1'b0;
    clearIn();
    reset = 1'b0;

    // Combinational vector table (FSM idle, sysD low).
    for (int i = 0; i < 13; i++) begin
      step();
      hz.RsD = vecs[i].RsD; hz.RtD = vecs[i].RtD; hz.RsE = vecs[i].RsE; hz.RtE = vecs[i].RtE;
      hz.WriteRegE = vecs[i].WrE; hz.RegWriteE = vecs[i].RwE; hz.MemtoRegE = vecs[i].MtrE;
      hz.WriteRegM = vecs[i].WrM; hz.RegWriteM = vecs[i].RwM; hz.MemtoRegM = vecs[i].MtrM;
      hz.WriteRegW = vecs[i].WrW; hz.RegWriteW = vecs[i].RwW; hz.BranchD = vecs[i].Br;
      #1;
      chk($sformatf("v%0d.ForwardAE", i), 32'(hz.ForwardAE), 32'(vecs[i].eAE));
      chk($sformatf("v%0d.ForwardBE", i), 32'(hz.ForwardBE), 32'(vecs[i].eBE));
      chk($sformatf("v%0d.ForwardAD", i), 32'(hz.ForwardAD), 32'(vecs[i].eAD));
      chk($sformatf("v%0d.ForwardBD", i), 32'(hz.ForwardBD), 32'(vecs[i].eBD));
      chk($sformatf("v%0d.StallD", i),    32'(hz.StallD),    32'(vecs[i].eStall));
      chk($sformatf("v%0d.FlushE", i),    32'(hz.FlushE),    32'(vecs[i].eStall));
    end
    step();
    clearIn();
    chk("table.stall_cnt", 32'(hz.stall_cnt), 32'd4);

    // Syscall from idle; sysD drops during DRAIN and must be ignored.
    hz.sysD = 1;
    step(); chkCtl("sys.d1", 1'b1, 1'b1, 1'b0);
    hz.sysD = 0;
    step(); chkCtl("sys.d2", 1'b1, 1'b1, 1'b0);
    step(); chkCtl("sys.d3", 1'b1, 1'b1, 1'b0);
    step(); chkCtl("sys.issue", 1'b0, 1'b0, 1'b1);
    step(); chkCtl("sys.idle", 1'b0, 1'b0, 1'b0);
    chk("sys.stall_cnt", 32'(hz.stall_cnt), 32'd7);

    // Syscall arriving together with a load-use stall.
    hz.sysD = 1; hz.MemtoRegE = 1; hz.RtE = 5'd8; hz.RtD = 5'd8;
    chkCtl("lwsys.bubble", 1'b1, 1'b1, 1'b0);
    step();
    hz.MemtoRegE = 0; hz.RtE = 0; hz.RtD = 0;
    #1; chk("lwsys.c1.sysGoD", 32'(hz.sysGoD), 32'd0);
    step(); chkCtl("lwsys.d1", 1'b1, 1'b1, 1'b0);
    step(); chkCtl("lwsys.d2", 1'b1, 1'b1, 1'b0);
    step(); chkCtl("lwsys.d3", 1'b1, 1'b1, 1'b0);
    step(); chkCtl("lwsys.issue", 1'b0, 1'b0, 1'b1);
    hz.sysD = 0;
    step(); chkCtl("lwsys.idle", 1'b0, 1'b0, 1'b0);

    // Reset in the second DRAIN cycle.
    hz.sysD = 1;
    step(); chkCtl("rsys.d1", 1'b1, 1'b1, 1'b0);
    step();
    reset = 1'b1; hz.sysD = 0;
    hz.RsE = 5'd5; hz.WriteRegM = 5'd5; hz.RegWriteM = 1;
    chkCtl("rsys.inrst", 1'b0, 1'b1, 1'b0);
    chk("rsys.inrst.ForwardAE", 32'(hz.ForwardAE), 32'd0);
    step();
    reset = 1'b0;
    chkCtl("rsys.after", 1'b0, 1'b0, 1'b0);
    chk("rsys.ForwardAE", 32'(hz.ForwardAE), 32'b10);
    chk("rsys.stall_cnt", 32'(hz.stall_cnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(); chkCtl($sformatf("rsys.noissue%0d", i), 1'b0, 1'b0, 1'b0);
    end

    // Saturation on the 4-bit counter instance (released from reset at the start).
    chk("sat.nonzero", 32'(hz2.stall_cnt != 0), 32'd1);
    for (int i = 0; i < 25; i++) step();
    chk("sat.stall_cnt", 32'(hz2.stall_cnt), 32'd15);
    chk("sat.StallD", 32'(hz2.StallD), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
